// File: rtl/md_enc_pkg.sv
// md_enc_pkg: shared button/pin indices, phase type and output-select encoding for the Mega Drive pad encoder
package md_enc_pkg;
    localparam int BTN_UP = 0;
    localparam int BTN_DW = 1;
    localparam int BTN_LF = 2;
    localparam int BTN_RG = 3;
    localparam int BTN_A  = 4;
    localparam int BTN_B  = 5;
    localparam int BTN_C  = 6;
    localparam int BTN_ST = 7;
    localparam int BTN_X  = 8;
    localparam int BTN_Y  = 9;
    localparam int BTN_Z  = 10;
    localparam int BTN_MD = 11;

    localparam int DB_P9 = 0;
    localparam int DB_P6 = 1;
    localparam int DB_P4 = 2;
    localparam int DB_P3 = 3;
    localparam int DB_P2 = 4;
    localparam int DB_P1 = 5;

    typedef logic [2:0] phase_t;

    typedef enum logic [2:0] {SEL_NORM_HI, SEL_XYZ, SEL_NORM_LO, SEL_ZERO, SEL_ONES} sel_t;

    function automatic phase_t sat7(phase_t p);
        return (p == 3'd7) ? p : p + 3'd1;
    endfunction

    function automatic sel_t out_sel(logic s, phase_t p);
        return s ? ((p == 3'd4 || p == 3'd5) ? SEL_XYZ : SEL_NORM_HI)
                 : ((p == 3'd3 || p == 3'd4) ? SEL_ZERO :
                    (p == 3'd5 || p == 3'd6) ? SEL_ONES : SEL_NORM_LO);
    endfunction
endpackage

// File: rtl/md_enc_port.sv
// md_enc_port: one pad channel - p7 synchroniser, edge count with timeout, registered DB9 output mux
//   clk, rst_n (sync, active-low) | p7: async select pin | btn[11]..[0]={md,z,y,x,st,c,b,a,rg,lf,dw,up} active-low
//   mode3: hold in three-button behaviour | db_out[5:0]={p1,p2,p3,p4,p6,p9}
module md_enc_port
    import md_enc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 36000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p7,
    input  logic [11:0] btn,
    input  logic        mode3,
    output logic [5:0]  db_out
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_prev, edge_det;
    phase_t                 phase;
    logic [TW-1:0]          timer;
    sel_t                   sel;
    logic [5:0]             nxt;

    assign s        = sync[SYNC_STAGES-1];
    assign edge_det = s ^ s_prev;

    always_comb begin
        sel = out_sel(s, phase);
        nxt = (sel == SEL_XYZ)     ? {btn[BTN_Z], btn[BTN_Y], btn[BTN_X], btn[BTN_MD], 2'b11} :
              (sel == SEL_NORM_LO) ? {btn[BTN_UP], btn[BTN_DW], 2'b00, btn[BTN_A], btn[BTN_ST]} :
              (sel == SEL_ZERO)    ? {4'b0000, btn[BTN_A], btn[BTN_ST]} :
              (sel == SEL_ONES)    ? {4'b1111, btn[BTN_A], btn[BTN_ST]} :
                                     {btn[BTN_UP], btn[BTN_DW], btn[BTN_LF], btn[BTN_RG], btn[BTN_B], btn[BTN_C]};
    end

    // An edge landing on the expiry cycle counts from an already-cleared phase, hence 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= '1;
            s_prev <= 1'b1;
            phase  <= '0;
            timer  <= RELOAD;
            db_out <= '1;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], p7};
            s_prev <= s;
            db_out <= nxt;
            if (mode3) begin
                phase <= '0;
                timer <= RELOAD;
            end else if (edge_det) begin
                phase <= (timer == '0) ? 3'd1 : sat7(phase);
                timer <= RELOAD;
            end else if (timer == '0) begin
                phase <= '0;
                timer <= RELOAD;
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end
endmodule

// File: rtl/md_multi_pad_encoder.sv
// md_multi_pad_encoder: N-port synchronous Mega Drive six-button pad encoder with optional autofire (MD_ENC_TURBO_EN)
//   clk, rst_n (sync, active-low) | p7[N]: select pins | btn[12N]: per-port active-low buttons
//   mode3[N]: forced three-button | turbo_msk[3N]: {c,b,a} autofire enables (MD_ENC_TURBO_EN only)
//   db_out[6N]: per port {p1,p2,p3,p4,p6,p9}
module md_multi_pad_encoder
    import md_enc_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int CLK_FREQ    = 20000000,
    parameter int TIMEOUT_US  = 1800,
    parameter int SYNC_STAGES = 2,
    parameter int TURBO_HZ    = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PORTS-1:0]   p7,
    input  logic [12*NUM_PORTS-1:0] btn,
    input  logic [NUM_PORTS-1:0]   mode3,
`ifdef MD_ENC_TURBO_EN
    input  logic [3*NUM_PORTS-1:0] turbo_msk,
`endif
    output logic [6*NUM_PORTS-1:0] db_out
);
    localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;

    logic [12*NUM_PORTS-1:0] btn_eff;

`ifdef MD_ENC_TURBO_EN
    localparam int TDIV = CLK_FREQ / (2 * TURBO_HZ);
    localparam int DW   = $clog2(TDIV + 1);

    logic [DW-1:0] div;
    logic          turbo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div   <= '0;
            turbo <= 1'b0;
        end else if (div == DW'(TDIV - 1)) begin
            div   <= '0;
            turbo <= ~turbo;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Held (0) buttons with autofire enabled read as released while turbo is high.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_turbo
        assign btn_eff[12*i +: 12] = btn[12*i +: 12] | {5'b0, turbo_msk[3*i +: 3] & {3{turbo}}, 4'b0};
    end
`else
    assign btn_eff = btn;
`endif

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        md_enc_port #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_port (
            .clk   (clk),
            .rst_n (rst_n),
            .p7    (p7[i]),
            .btn   (btn_eff[12*i +: 12]),
            .mode3 (mode3[i]),
            .db_out(db_out[6*i +: 6])
        );
    end
endmodule
